// File: rtl/kpn_pkg.sv
// Shared definitions for arithmetic KPN process nodes.
// Holds the default token width, FSM state encoding and token type.
package kpn_pkg;

    localparam int BITS_NUMBER = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        LATCH = 2'd2,
        WRITE = 2'd3
    } kpn_state_t;

    typedef logic [BITS_NUMBER-1:0] token_t;

endpackage

// File: rtl/kpn_sat_adder.sv
// Combinational unsigned adder with carry-out and optional clamp to all-ones.
// Shared by the arithmetic KPN nodes.
module kpn_sat_adder #(
    parameter int BITS_NUMBER = kpn_pkg::BITS_NUMBER,
    parameter int SATURATE    = 0
) (
    input  logic [BITS_NUMBER-1:0] a,
    input  logic [BITS_NUMBER-1:0] b,
    output logic [BITS_NUMBER-1:0] sum,
    output logic                   carry
);

    logic [BITS_NUMBER:0] full_sum;

    assign full_sum = {1'b0, a} + {1'b0, b};
    assign carry    = full_sum[BITS_NUMBER];

    always_comb begin
        sum = full_sum[BITS_NUMBER-1:0];
        if (SATURATE != 0 && carry) begin
            sum = '1;
        end
    end

endmodule

// File: rtl/kpn_add_process.sv
// KPN node: pops one token from each input FIFO, adds them and pushes the sum
// downstream with blocking-read / blocking-write semantics.
module kpn_add_process
    import kpn_pkg::*;
#(
    parameter int BITS_NUMBER = kpn_pkg::BITS_NUMBER,
    parameter int SATURATE    = 0,
    parameter int COUNT_BITS  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [BITS_NUMBER-1:0] in_a_data,
    input  logic                   in_a_empty,
    output logic                   in_a_rd,
    input  logic [BITS_NUMBER-1:0] in_b_data,
    input  logic                   in_b_empty,
    output logic                   in_b_rd,
    output logic [BITS_NUMBER-1:0] out_data,
    input  logic                   out_full,
    output logic                   out_wr,
    output logic [COUNT_BITS-1:0]  token_count,
    output logic                   overflow,
    output logic                   busy
);

    kpn_state_t state_reg, state_next;

    logic [BITS_NUMBER-1:0] sum;
    logic                   carry;

    kpn_sat_adder #(
        .BITS_NUMBER(BITS_NUMBER),
        .SATURATE   (SATURATE)
    ) u_adder (
        .a    (in_a_data),
        .b    (in_b_data),
        .sum  (sum),
        .carry(carry)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_a_rd    = 1'b0;
        in_b_rd    = 1'b0;
        out_wr     = 1'b0;
        busy       = (state_reg != IDLE);
        unique case (state_reg)
            IDLE: begin
                // Both inputs must be available together; no partial pops.
                if (!in_a_empty && !in_b_empty) begin
                    state_next = READ;
                end
            end
            READ: begin
                in_a_rd    = 1'b1;
                in_b_rd    = 1'b1;
                state_next = LATCH;
            end
            LATCH: begin
                state_next = WRITE;
            end
            WRITE: begin
                if (!out_full) begin
                    out_wr     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO read data is valid in LATCH, one cycle after the read strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data    <= '0;
            token_count <= '0;
            overflow    <= 1'b0;
        end else begin
            if (state_reg == LATCH) begin
                out_data <= sum;
                if (carry) begin
                    overflow <= 1'b1;
                end
            end
            if (out_wr) begin
                token_count <= token_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kpn_add_process.sv
// Self-checking bench for kpn_add_process: wrapping and saturating instances
// share small input FIFO models; directed table plus multi-cycle sequences.
module tb_kpn_add_process;

    localparam int W  = 16;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [W-1:0] a_mem [256];
    logic [W-1:0] b_mem [256];
    int a_wp = 0, a_rp = 0, b_wp = 0, b_rp = 0;
    logic [W-1:0] a_data = '0, b_data = '0;
    logic a_empty, b_empty, out_full;

    logic          rd_a0, rd_b0, wr0, ovf0, busy0;
    logic [W-1:0]  data0;
    logic [CW-1:0] cnt0;
    logic          rd_a1, rd_b1, wr1, ovf1, busy1;
    logic [W-1:0]  data1;
    logic [CW-1:0] cnt1;

    assign a_empty = (a_wp == a_rp);
    assign b_empty = (b_wp == b_rp);

    kpn_add_process #(.BITS_NUMBER(W), .SATURATE(0), .COUNT_BITS(CW)) dut0 (
        .clk(clk), .reset(reset),
        .in_a_data(a_data), .in_a_empty(a_empty), .in_a_rd(rd_a0),
        .in_b_data(b_data), .in_b_empty(b_empty), .in_b_rd(rd_b0),
        .out_data(data0), .out_full(out_full), .out_wr(wr0),
        .token_count(cnt0), .overflow(ovf0), .busy(busy0)
    );

    kpn_add_process #(.BITS_NUMBER(W), .SATURATE(1), .COUNT_BITS(CW)) dut1 (
        .clk(clk), .reset(reset),
        .in_a_data(a_data), .in_a_empty(a_empty), .in_a_rd(rd_a1),
        .in_b_data(b_data), .in_b_empty(b_empty), .in_b_rd(rd_b1),
        .out_data(data1), .out_full(out_full), .out_wr(wr1),
        .token_count(cnt1), .overflow(ovf1), .busy(busy1)
    );

    // Input FIFO models: registered read data valid the cycle after rd.
    always @(posedge clk) begin
        if (rd_a0 && a_rp != a_wp) begin
            a_data <= a_mem[a_rp[7:0]];
            a_rp   <= a_rp + 1;
        end
        if (rd_b0 && b_rp != b_wp) begin
            b_data <= b_mem[b_rp[7:0]];
            b_rp   <= b_rp + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output FIFO samples on negedge.
    logic [W-1:0] log_data [128];
    int           log_cyc  [128];
    int           wr_n = 0;
    always @(negedge clk) begin
        if (wr0) begin
            log_data[wr_n[6:0]] <= data0;
            log_cyc[wr_n[6:0]]  <= cyc;
            wr_n                <= wr_n + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
        a_mem[a_wp[7:0]] = a;
        a_wp++;
        b_mem[b_wp[7:0]] = b;
        b_wp++;
    endtask

    task automatic wait_wr(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (wr0) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] sum_wrap;
        logic [W-1:0] sum_sat;
        logic         carry;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int   cnt_exp;
        logic ovf_exp;
        int   bad;
        int   base;

        vecs[0] = '{16'h0001, 16'h0001, 16'h0002, 16'h0002, 1'b0};
        vecs[1] = '{16'h1234, 16'h4321, 16'h5555, 16'h5555, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 16'h8000, 16'h8000, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0002, 16'h0001, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 16'h0000, 16'hFFFF, 1'b1};
        vecs[5] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0};

        reset    = 1'b1;
        out_full = 1'b0;
        step();
        step();
        chk("reset_rd_a", rd_a0, 0);
        chk("reset_rd_b", rd_b1, 0);
        chk("reset_wr", wr0, 0);
        chk("reset_data", data0, 0);
        chk("reset_count", cnt0, 0);
        chk("reset_ovf", ovf0, 0);
        chk("reset_busy", busy0, 0);
        reset = 1'b0;
        step();

        // 5 + 7: rd at t+1, wr at t+3
        push(16'd5, 16'd7);
        step();
        chk("t1_rd_a", rd_a0, 1);
        chk("t1_rd_b", rd_b0, 1);
        chk("t1_rd_a_sat", rd_a1, 1);
        chk("t1_busy", busy0, 1);
        step();
        chk("t2_rd_low", rd_a0, 0);
        chk("t2_wr_low", wr0, 0);
        step();
        chk("t3_wr", wr0, 1);
        chk("t3_data", data0, 12);
        step();
        chk("t4_wr_low", wr0, 0);
        chk("t4_count", cnt0, 1);
        chk("t4_ovf", ovf0, 0);
        chk("t4_busy", busy0, 0);

        // A non-empty, B empty: no partial read
        a_mem[a_wp[7:0]] = 16'd3;
        a_wp++;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (rd_a0 || rd_b0 || busy0) bad++;
        end
        chk("partial_idle", bad, 0);
        b_mem[b_wp[7:0]] = 16'd4;
        b_wp++;
        step();
        chk("partial_pop", rd_a0, 1);
        wait_wr("partial");
        chk("partial_data", data0, 7);
        step();
        chk("partial_count", cnt0, 2);

        // Blocking write with out_full
        out_full = 1'b1;
        base = wr_n;
        push(16'd4, 16'd5);
        step();
        step();
        step();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (wr0 || data0 != 16'd9 || !busy0) bad++;
            step();
        end
        chk("full_hold", bad, 0);
        chk("full_data", data0, 9);
        out_full = 1'b0;
        #1;
        chk("full_release_wr", wr0, 1);
        step();
        chk("full_after_wr", wr0, 0);
        chk("full_count", cnt0, 3);
        chk("full_pulses", wr_n - base, 1);

        // Table: wrap vs saturate, sticky overflow
        cnt_exp = 3;
        ovf_exp = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push(vecs[i].a, vecs[i].b);
            wait_wr($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_wrap", i), data0, vecs[i].sum_wrap);
            chk($sformatf("vec%0d_sat", i), data1, vecs[i].sum_sat);
            step();
            cnt_exp++;
            ovf_exp = ovf_exp | vecs[i].carry;
            chk($sformatf("vec%0d_ovf", i), ovf0, ovf_exp);
            chk($sformatf("vec%0d_ovf_sat", i), ovf1, ovf_exp);
            chk($sformatf("vec%0d_count", i), cnt0, cnt_exp);
            chk($sformatf("vec%0d_count_sat", i), cnt1, cnt_exp);
        end

        // Reset asserted during LATCH
        push(16'd1, 16'd1);
        step();
        step();
        chk("latch_busy", busy0, 1);
        reset = 1'b1;
        #1;
        chk("rst_rd", rd_a0, 0);
        chk("rst_wr", wr0, 0);
        chk("rst_data", data0, 0);
        chk("rst_count", cnt0, 0);
        chk("rst_ovf", ovf0, 0);
        chk("rst_ovf_sat", ovf1, 0);
        chk("rst_busy", busy0, 0);
        step();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (busy0 || rd_a0 || wr0) bad++;
        end
        chk("rst_stays_idle", bad, 0);

        // Stream 40 pairs (i, 2i)
        base = wr_n;
        for (int i = 0; i < 40; i++) push(16'(i), 16'(2 * i));
        for (int i = 0; i < 250 && (wr_n - base) < 40; i++) step();
        for (int i = 0; i < 10; i++) step();
        chk("stream_pulses", wr_n - base, 40);
        for (int i = 0; i < 40; i++) begin
            chk($sformatf("stream_data%0d", i), log_data[(base + i) % 128], 3 * i);
            if (i > 0)
                chk($sformatf("stream_gap%0d", i),
                    log_cyc[(base + i) % 128] - log_cyc[(base + i - 1) % 128], 4);
        end
        chk("stream_count", cnt0, 40);
        chk("stream_ovf", ovf0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
